// File: rtl/inst_prefetch_if.sv
// Fetch-side bus of the prefetch queue: RAM request/response, cpu head handshake and redirect.
interface inst_prefetch_if;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        inst_valid;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        inst_ready;
  logic        redirect;
  logic [31:0] redirect_pc;

  modport master (
    output mem_req, mem_addr, inst_valid, inst_data, inst_pc,
    input  mem_rdata, inst_ready, redirect, redirect_pc
  );
  modport slave (
    input  mem_req, mem_addr, inst_valid, inst_data, inst_pc,
    output mem_rdata, inst_ready, redirect, redirect_pc
  );
endinterface

// File: rtl/inst_prefetch.sv
// Instruction prefetch queue: sequential word fetches from a 1-cycle RAM, DEPTH-entry buffer
// of {inst, pc}, valid/ready head and redirect flush.
module inst_prefetch #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic          clk,
  input  logic          rst,
  inst_prefetch_if.master bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [31:0]   r_data [DEPTH];
  logic [31:0]   r_pc   [DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [CW-1:0] r_count;
  logic [31:0]   r_fetch_pc, r_req_pc;
  logic          r_inflight, r_drop;

  logic          w_mem_req, w_push, w_pop;
  logic [CW-1:0] w_used;

  // The in-flight fetch holds a credit so its response always finds a free slot.
  assign w_used    = r_count + CW'(r_inflight);
  assign w_mem_req = ~rst & ~bus.redirect & (w_used < CW'(DEPTH));
  assign w_push    = r_inflight & ~r_drop;
  assign w_pop     = (r_count != '0) & bus.inst_ready;

  assign bus.mem_req    = w_mem_req;
  assign bus.mem_addr   = r_fetch_pc;
  assign bus.inst_valid = (r_count != '0);
  assign bus.inst_data  = r_data[r_rptr];
  assign bus.inst_pc    = r_pc[r_rptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fetch_pc <= RESET_PC;
      r_req_pc   <= '0;
      r_inflight <= 1'b0;
      r_drop     <= 1'b0;
      r_count    <= '0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_data[i] <= '0;
        r_pc[i]   <= '0;
      end
    end else begin
      r_inflight <= w_mem_req;
      if (w_mem_req) begin
        r_fetch_pc <= r_fetch_pc + 32'd4;
        r_req_pc   <= r_fetch_pc;
      end
      if (bus.redirect) begin
        // Redirect beats push and pop: the response landing now and any pop are both lost.
        r_fetch_pc <= {bus.redirect_pc[31:2], 2'b00};
        r_count    <= '0;
        r_wptr     <= '0;
        r_rptr     <= '0;
        r_drop     <= w_mem_req;
      end else begin
        if (r_inflight) r_drop <= 1'b0;
        if (w_push) begin
          r_data[r_wptr] <= bus.mem_rdata;
          r_pc[r_wptr]   <= r_req_pc;
          r_wptr         <= r_wptr + AW'(1);
        end
        if (w_pop) r_rptr <= r_rptr + AW'(1);
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + CW'(1);
          2'b01:   r_count <= r_count - CW'(1);
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_inst_prefetch.sv
// Directed and random checks of inst_prefetch against a stream-level model of the fetch rules.
module tb_inst_prefetch;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_assert = 0;
  int   n_fail   = 0;

  logic        poison = 1'b0;
  logic [31:0] poison_addr = 32'h0;

  inst_prefetch_if bus();

  inst_prefetch #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ramw(input logic [31:0] a);
    return 32'h1000_0000 + {10'b0, a[23:2]};
  endfunction

  // Synchronous RAM: data for a request appears in the following cycle.
  always @(posedge clk)
    if (bus.mem_req)
      bus.mem_rdata <= (poison && bus.mem_addr == poison_addr) ? 32'hDEAD_BEEF : ramw(bus.mem_addr);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nreq;
    int nacc;
    int outstanding;
    logic [31:0] exp_pc;

    bus.inst_ready  = 1'b1;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 32'h0;
    bus.mem_rdata   = 32'h0;

    // 1: reset state, then one instruction per cycle from RESET_PC
    tick(); tick();
    chk("rst_valid", {31'b0, bus.inst_valid}, 32'd0);
    chk("rst_req",   {31'b0, bus.mem_req},    32'd0);
    chk("rst_data",  bus.inst_data, 32'h0);
    chk("rst_pc",    bus.inst_pc,   32'h0);
    tick(); rst = 1'b0; #1;
    chk("t1_req0",  {31'b0, bus.mem_req}, 32'd1);
    chk("t1_addr0", bus.mem_addr, 32'h0);
    tick();
    chk("t1_valid1", {31'b0, bus.inst_valid}, 32'd0);
    chk("t1_addr1",  bus.mem_addr, 32'h4);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("t1_valid", {31'b0, bus.inst_valid}, 32'd1);
      chk("t1_pc",    bus.inst_pc,   32'(4 * i));
      chk("t1_data",  bus.inst_data, ramw(32'(4 * i)));
    end

    // 2: no ready from reset -> exactly DEPTH requests, then drain in order
    rst = 1'b1; bus.inst_ready = 1'b0;
    tick();
    rst = 1'b0; #1;
    nreq = 0;
    for (int c = 0; c < 8; c++) begin
      if (c > 0) tick();
      if (bus.mem_req) begin
        chk("t2_addr", bus.mem_addr, 32'(4 * nreq));
        nreq++;
      end
    end
    chk("t2_nreq",  32'(nreq), 32'd4);
    chk("t2_stall", {31'b0, bus.mem_req},    32'd0);
    chk("t2_full",  {31'b0, bus.inst_valid}, 32'd1);
    chk("t2_head",  bus.inst_pc, 32'h0);
    tick(); bus.inst_ready = 1'b1; #1;
    for (int i = 0; i < 12; i++) begin
      if (i > 0) tick();
      chk("t2_valid", {31'b0, bus.inst_valid}, 32'd1);
      chk("t2_pc",    bus.inst_pc,   32'(4 * i));
      chk("t2_data",  bus.inst_data, ramw(32'(4 * i)));
    end

    // 3: redirect from a steady stream to an unaligned target
    tick(); bus.redirect = 1'b1; bus.redirect_pc = 32'h0000_0042; #1;
    chk("t3_req_R", {31'b0, bus.mem_req}, 32'd0);
    tick(); bus.redirect = 1'b0; #1;
    chk("t3_addr_R1",  bus.mem_addr, 32'h40);
    chk("t3_req_R1",   {31'b0, bus.mem_req},    32'd1);
    chk("t3_valid_R1", {31'b0, bus.inst_valid}, 32'd0);
    tick();
    chk("t3_valid_R2", {31'b0, bus.inst_valid}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t3_valid", {31'b0, bus.inst_valid}, 32'd1);
      chk("t3_pc",    bus.inst_pc,   32'h40 + 32'(4 * i));
      chk("t3_data",  bus.inst_data, ramw(32'h40 + 32'(4 * i)));
    end

    // 4: credit-full queue with a poisoned in-flight response, redirect coincident with pop
    poison = 1'b1; poison_addr = 32'h10C;
    tick(); bus.redirect = 1'b1; bus.redirect_pc = 32'h100; bus.inst_ready = 1'b0; #1;
    tick(); bus.redirect = 1'b0; #1;
    for (int i = 0; i < 3; i++) tick();
    chk("t4_addr_last", bus.mem_addr, 32'h10C);
    chk("t4_req_last",  {31'b0, bus.mem_req}, 32'd1);
    tick();
    chk("t4_credit", {31'b0, bus.mem_req},    32'd0);
    chk("t4_head",   bus.inst_pc,             32'h100);
    chk("t4_hvalid", {31'b0, bus.inst_valid}, 32'd1);
    bus.inst_ready = 1'b1; bus.redirect = 1'b1; bus.redirect_pc = 32'h200; #1;
    chk("t4_req_R", {31'b0, bus.mem_req}, 32'd0);
    tick(); bus.redirect = 1'b0; #1;
    chk("t4_empty", {31'b0, bus.inst_valid}, 32'd0);
    tick();
    chk("t4_empty2", {31'b0, bus.inst_valid}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t4_valid", {31'b0, bus.inst_valid}, 32'd1);
      chk("t4_pc",    bus.inst_pc,   32'h200 + 32'(4 * i));
      chk("t4_data",  bus.inst_data, ramw(32'h200 + 32'(4 * i)));
    end
    poison = 1'b0;

    // 4b: back-to-back redirects, the last one wins
    tick(); bus.redirect = 1'b1; bus.redirect_pc = 32'h300; #1;
    tick(); bus.redirect_pc = 32'h400; #1;
    tick(); bus.redirect = 1'b0; #1;
    chk("t4b_addr", bus.mem_addr, 32'h400);
    tick(); tick();
    chk("t4b_valid", {31'b0, bus.inst_valid}, 32'd1);
    chk("t4b_pc",    bus.inst_pc, 32'h400);

    // 5: async reset mid-stream with fetch_pc = 0x80
    tick(); bus.redirect = 1'b1; bus.redirect_pc = 32'h70; #1;
    tick(); bus.redirect = 1'b0; #1;
    for (int i = 0; i < 4; i++) tick();
    chk("t5_addr",   bus.mem_addr, 32'h80);
    chk("t5_pre",    {31'b0, bus.inst_valid}, 32'd1);
    rst = 1'b1; #1;
    chk("t5_valid",  {31'b0, bus.inst_valid}, 32'd0);
    chk("t5_req",    {31'b0, bus.mem_req},    32'd0);
    chk("t5_pc_clr", bus.inst_pc, 32'h0);
    tick(); rst = 1'b0; #1;
    chk("t5_req0",  {31'b0, bus.mem_req}, 32'd1);
    chk("t5_addr0", bus.mem_addr, 32'h0);
    tick(); tick();
    chk("t5_first", {31'b0, bus.inst_valid}, 32'd1);
    chk("t5_pc0",   bus.inst_pc, 32'h0);

    // 6: random ready and redirects vs. a stream model
    rst = 1'b1; tick(); rst = 1'b0;
    exp_pc = 32'h0; outstanding = 0; nacc = 0;
    for (int c = 0; c < 1000; c++) begin
      if (c > 0) tick();
      bus.inst_ready  = 1'($urandom_range(0, 1));
      bus.redirect    = ($urandom_range(0, 39) == 0);
      bus.redirect_pc = (c == 500) ? 32'hFFFF_FFF6 : ($urandom & 32'h00FF_FFFF);
      #1;
      if (bus.redirect) begin
        exp_pc = bus.redirect_pc & ~32'h3;
        outstanding = 0;
      end else begin
        if (bus.inst_valid && bus.inst_ready) begin
          chk("r_pc",   bus.inst_pc,   exp_pc);
          chk("r_data", bus.inst_data, ramw(exp_pc));
          exp_pc += 32'd4;
          outstanding--;
          nacc++;
        end
        if (bus.mem_req) outstanding++;
        chk("r_occupancy", {31'b0, (outstanding <= DEPTH && outstanding >= 0)}, 32'd1);
      end
    end
    chk("r_progress", {31'b0, (nacc > 150)}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
